// File: rtl/sw_cond.sv
// -----------------------------------------------------------------------------
// sw_cond -- four-channel push-button conditioner
//
// Each active-low button is synchronised and debounced against a shared
// millisecond tick. The block reports debounced press and release events,
// a hold level for long presses, and auto-repeat pulses while a button stays
// held.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   i_sw[3:0]  raw buttons, active-low (0 = pressed), asynchronous to clk
//   o_press    one-clk pulse per channel on a debounced press
//   o_release  one-clk pulse per channel on a debounced release
//   o_hold     level per channel, high while a long press is in progress
//   o_repeat   one-clk pulse at hold entry, then every RPT_MS ticks while held
//
// Parameters
//   TICK_DIV   clk cycles per 1 ms tick (2 .. 2^20)
//   DB_MS      debounce time in ticks (1 .. 65535)
//   LONG_MS    press duration in ticks before hold/auto-repeat (DB_MS+1 .. 65535)
//   RPT_MS     auto-repeat period in ticks (1 .. 65535)
// -----------------------------------------------------------------------------
module sw_cond #(
    parameter int TICK_DIV = 50000,
    parameter int DB_MS    = 10,
    parameter int LONG_MS  = 1000,
    parameter int RPT_MS   = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_sw,
    output logic [3:0] o_press,
    output logic [3:0] o_release,
    output logic [3:0] o_hold,
    output logic [3:0] o_repeat
);

    localparam int              PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]   PRESC_ONE  = PW'(1'b1);

    // Counters compare against "last" values so the transition happens on the
    // very tick that brings the count to its target.
    localparam logic [15:0]     DB_LAST    = 16'(DB_MS - 1);
    localparam logic [15:0]     LONG_LAST  = 16'(LONG_MS - 1);
    localparam logic [15:0]     RPT_LAST   = 16'(RPT_MS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DEB_PRESS = 3'd1,
        ST_PRESSED   = 3'd2,
        ST_HELD      = 3'd3,
        ST_DEB_REL   = 3'd4
    } state_t;

    logic [3:0]    sync1_r;
    logic [3:0]    sync2_r;
    logic [PW-1:0] presc_r;
    logic          tick_s;

    state_t        state_r    [4];
    state_t        state_nxt_s[4];
    logic [15:0]   db_r       [4];
    logic [15:0]   db_nxt_s   [4];
    logic [15:0]   dur_r      [4];
    logic [15:0]   dur_nxt_s  [4];

    logic [3:0]    press_nxt_s;
    logic [3:0]    release_nxt_s;
    logic [3:0]    repeat_nxt_s;
    logic [3:0]    hold_nxt_s;

    // Two-flop synchronizer; idles at 1 (released) so reset never fakes a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 4'hF;
            sync2_r <= 4'hF;
        end else begin
            sync1_r <= i_sw;
            sync2_r <= sync1_r;
        end
    end

    // Free-running millisecond prescaler shared by all channels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= '0;
        end else if (presc_r == PRESC_LAST) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PRESC_ONE;
        end
    end

    assign tick_s = (presc_r == PRESC_LAST);

    // Per-channel next-state and event logic. A level change always wins over
    // a coincident tick, so that tick is simply not counted. o_hold doubles as
    // the "came from HELD" memory used when a release bounce is rejected.
    always_comb begin
        press_nxt_s   = 4'h0;
        release_nxt_s = 4'h0;
        repeat_nxt_s  = 4'h0;
        hold_nxt_s    = o_hold;
        for (int ch = 0; ch < 4; ch++) begin
            state_nxt_s[ch] = state_r[ch];
            db_nxt_s[ch]    = db_r[ch];
            dur_nxt_s[ch]   = dur_r[ch];
            case (state_r[ch])
                ST_IDLE: begin
                    if (!sync2_r[ch]) begin
                        state_nxt_s[ch] = ST_DEB_PRESS;
                        db_nxt_s[ch]    = 16'd0;
                    end else begin
                        state_nxt_s[ch] = ST_IDLE;
                    end
                end
                ST_DEB_PRESS: begin
                    if (sync2_r[ch]) begin
                        state_nxt_s[ch] = ST_IDLE;
                    end else if (tick_s) begin
                        if (db_r[ch] == DB_LAST) begin
                            state_nxt_s[ch] = ST_PRESSED;
                            dur_nxt_s[ch]   = 16'd0;
                            press_nxt_s[ch] = 1'b1;
                        end else begin
                            db_nxt_s[ch] = db_r[ch] + 16'd1;
                        end
                    end else begin
                        state_nxt_s[ch] = ST_DEB_PRESS;
                    end
                end
                ST_PRESSED: begin
                    if (sync2_r[ch]) begin
                        state_nxt_s[ch] = ST_DEB_REL;
                        db_nxt_s[ch]    = 16'd0;
                    end else if (tick_s) begin
                        if (dur_r[ch] == LONG_LAST) begin
                            state_nxt_s[ch]  = ST_HELD;
                            dur_nxt_s[ch]    = 16'd0;
                            hold_nxt_s[ch]   = 1'b1;
                            repeat_nxt_s[ch] = 1'b1;
                        end else begin
                            dur_nxt_s[ch] = dur_r[ch] + 16'd1;
                        end
                    end else begin
                        state_nxt_s[ch] = ST_PRESSED;
                    end
                end
                ST_HELD: begin
                    if (sync2_r[ch]) begin
                        state_nxt_s[ch] = ST_DEB_REL;
                        db_nxt_s[ch]    = 16'd0;
                    end else if (tick_s) begin
                        if (dur_r[ch] == RPT_LAST) begin
                            dur_nxt_s[ch]    = 16'd0;
                            repeat_nxt_s[ch] = 1'b1;
                        end else begin
                            dur_nxt_s[ch] = dur_r[ch] + 16'd1;
                        end
                    end else begin
                        state_nxt_s[ch] = ST_HELD;
                    end
                end
                ST_DEB_REL: begin
                    if (!sync2_r[ch]) begin
                        // Bounce rejected: resume where we were, dur untouched.
                        state_nxt_s[ch] = o_hold[ch] ? ST_HELD : ST_PRESSED;
                    end else if (tick_s) begin
                        if (db_r[ch] == DB_LAST) begin
                            state_nxt_s[ch]   = ST_IDLE;
                            release_nxt_s[ch] = 1'b1;
                            hold_nxt_s[ch]    = 1'b0;
                        end else begin
                            db_nxt_s[ch] = db_r[ch] + 16'd1;
                        end
                    end else begin
                        state_nxt_s[ch] = ST_DEB_REL;
                    end
                end
                default: begin
                    state_nxt_s[ch] = ST_IDLE;
                    db_nxt_s[ch]    = 16'd0;
                    dur_nxt_s[ch]   = 16'd0;
                    hold_nxt_s[ch]  = 1'b0;
                end
            endcase
        end
    end

    // Channel state and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < 4; ch++) begin
                state_r[ch] <= ST_IDLE;
                db_r[ch]    <= 16'd0;
                dur_r[ch]   <= 16'd0;
            end
        end else begin
            for (int ch = 0; ch < 4; ch++) begin
                state_r[ch] <= state_nxt_s[ch];
                db_r[ch]    <= db_nxt_s[ch];
                dur_r[ch]   <= dur_nxt_s[ch];
            end
        end
    end

    // Registered event outputs; they update on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_press   <= 4'h0;
            o_release <= 4'h0;
            o_repeat  <= 4'h0;
            o_hold    <= 4'h0;
        end else begin
            o_press   <= press_nxt_s;
            o_release <= release_nxt_s;
            o_repeat  <= repeat_nxt_s;
            o_hold    <= hold_nxt_s;
        end
    end

endmodule

// File: tb/tb_sw_cond.sv
// -----------------------------------------------------------------------------
// tb_sw_cond -- scoreboard bench for sw_cond
//
// A reference model describes each button as a debounced up/down level plus
// the total number of ticks it has been held; expected pulses are queued per
// clock and a separate monitor compares them with what the DUT presents.
// -----------------------------------------------------------------------------
module tb_sw_cond;

    localparam int TICK_DIV = 4;
    localparam int DB_MS    = 3;
    localparam int LONG_MS  = 10;
    localparam int RPT_MS   = 4;

    logic       clk;
    logic       rst;
    logic [3:0] i_sw;
    logic [3:0] o_press;
    logic [3:0] o_release;
    logic [3:0] o_hold;
    logic [3:0] o_repeat;

    sw_cond #(
        .TICK_DIV (TICK_DIV),
        .DB_MS    (DB_MS),
        .LONG_MS  (LONG_MS),
        .RPT_MS   (RPT_MS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_sw      (i_sw),
        .o_press   (o_press),
        .o_release (o_release),
        .o_hold    (o_hold),
        .o_repeat  (o_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] p;
        logic [3:0] r;
        logic [3:0] q;
    } ev_t;

    ev_t        sbq[$];
    int         vectors;
    int         miscompares;
    int         cyc;
    logic [3:0] exp_hold;

    // model state
    logic [3:0] m_s1, m_s2, m_prev;
    int         m_presc;
    bit         down[4];
    int         stab[4];
    int         held[4];

    // Reference model: evaluated on each rising edge using the values seen
    // before the edge, producing the outputs that should appear after it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1     = 4'hF;
            m_s2     = 4'hF;
            m_prev   = 4'hF;
            m_presc  = 0;
            exp_hold = 4'h0;
            for (int c = 0; c < 4; c++) begin
                down[c] = 1'b0;
                stab[c] = 0;
                held[c] = 0;
            end
            sbq.delete();
        end else begin
            logic [3:0] lvl, p, r, q;
            bit tick;
            ev_t e;
            lvl  = m_s2;
            tick = (m_presc == TICK_DIV - 1);
            p = 4'h0; r = 4'h0; q = 4'h0;
            for (int c = 0; c < 4; c++) begin
                bit want_down;
                want_down = !lvl[c];
                if (lvl[c] != m_prev[c]) begin
                    stab[c] = 0;            // any level change restarts debounce
                end else if (want_down != down[c]) begin
                    if (tick) stab[c]++;
                    if (stab[c] == DB_MS) begin
                        stab[c] = 0;
                        down[c] = want_down;
                        if (want_down) begin
                            held[c] = 0;
                            p[c] = 1'b1;
                        end else begin
                            exp_hold[c] = 1'b0;
                            r[c] = 1'b1;
                        end
                    end
                end else if (down[c] && tick) begin
                    held[c]++;
                    if (held[c] == LONG_MS) begin
                        exp_hold[c] = 1'b1;
                        q[c] = 1'b1;
                    end else if (held[c] > LONG_MS && ((held[c] - LONG_MS) % RPT_MS) == 0) begin
                        q[c] = 1'b1;
                    end
                end
            end
            cyc++;
            if ((p | r | q) != 4'h0) begin
                e.cyc = cyc; e.p = p; e.r = r; e.q = q;
                sbq.push_back(e);
            end
            m_prev  = lvl;
            m_presc = (m_presc == TICK_DIV - 1) ? 0 : m_presc + 1;
            m_s2    = m_s1;
            m_s1    = i_sw;
        end
    end

    // Monitor: compares DUT pulses and hold level against the scoreboard.
    always @(negedge clk) begin
        ev_t e;
        logic [3:0] ep, er, eq;
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            e = sbq.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_event cyc=%0d expected press=%b release=%b repeat=%b, DUT outputs stayed idle",
                     e.cyc, e.p, e.r, e.q);
        end
        ep = 4'h0; er = 4'h0; eq = 4'h0;
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            e  = sbq.pop_front();
            ep = e.p; er = e.r; eq = e.q;
        end
        if ((o_press | o_release | o_repeat | ep | er | eq) != 4'h0) begin
            vectors++;
            if (o_press !== ep || o_release !== er || o_repeat !== eq) begin
                miscompares++;
                $display("FAIL pulses cyc=%0d got press=%b release=%b repeat=%b want press=%b release=%b repeat=%b",
                         cyc, o_press, o_release, o_repeat, ep, er, eq);
            end
        end
        vectors++;
        if (o_hold !== exp_hold) begin
            miscompares++;
            $display("FAIL hold cyc=%0d got %b want %b", cyc, o_hold, exp_hold);
        end
    end

    task automatic drive(input logic [3:0] v, input int n);
        @(negedge clk);
        #1;
        i_sw = v;
        repeat (n) @(posedge clk);
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if ({o_press, o_release, o_repeat, o_hold} !== 16'h0) begin
            miscompares++;
            $display("FAIL %s got press=%b release=%b repeat=%b hold=%b want all 0",
                     name, o_press, o_release, o_repeat, o_hold);
        end
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rst         = 1'b1;
        i_sw        = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        @(negedge clk);
        #1;
        rst = 1'b0;

        drive(4'hF, 10);
        // short glitch on ch0: rejected
        drive(4'b1110, 8);
        drive(4'hF, 30);
        // tap on ch1
        drive(4'b1101, 40);
        drive(4'hF, 40);
        // long press on ch2 with hold and repeats
        drive(4'b1011, 120);
        drive(4'hF, 40);
        // held ch3 with a 5-clk release glitch
        drive(4'b0111, 80);
        drive(4'hF, 5);
        drive(4'b0111, 60);
        drive(4'hF, 40);
        // all four together
        drive(4'b0000, 30);
        drive(4'hF, 40);
        // reset while ch0 is held, button kept low
        drive(4'b1110, 80);
        pulse_rst();
        drive(4'b1110, 80);
        drive(4'hF, 40);
        // randomized bouncy traffic
        for (int i = 0; i < 80; i++) begin
            logic [3:0] v;
            int n;
            v = 4'($urandom_range(0, 15));
            n = (($urandom & 32'd3) == 32'd0) ? int'($urandom_range(1, 6))
                                               : int'($urandom_range(10, 70));
            drive(v, n);
        end
        drive(4'hF, 80);
        @(negedge clk);
        #1;
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
